// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Three registers (CTRL, PRESET, COUNT) are decoded from addr[3:2]; irq = irq_flag & CTRL.IM.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_auto;
  logic        w_cnt_zero;
  logic        w_load;
  logic        w_dec;
  logic        w_set_flag;
  logic        w_clr_en;
  logic        w_reload_clr;
  logic        w_unused_addr;

  assign w_wr_ctrl     = we && (addr[3:2] == A_CTRL);
  assign w_wr_preset   = we && (addr[3:2] == A_PRESET);
  assign w_auto        = (r_mode == 2'd1);
  assign w_cnt_zero    = (r_count == 32'd0);
  assign w_unused_addr = ^{addr[31:4], addr[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_en) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_CNT;
      S_CNT: begin
        if (!r_en)           w_state_nxt = S_IDLE;
        else if (w_cnt_zero) w_state_nxt = S_INT;
      end
      S_INT:  w_state_nxt = w_auto ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_set_flag   = 1'b0;
    w_clr_en     = 1'b0;
    w_reload_clr = 1'b0;
    case (r_state)
      S_LOAD: w_load = 1'b1;
      S_CNT: begin
        w_dec      = r_en && !w_cnt_zero;
        w_set_flag = r_en &&  w_cnt_zero;
      end
      S_INT: begin
        w_clr_en     = !w_auto;
        w_reload_clr =  w_auto;
      end
      default: ;
    endcase

    dout = 32'd0;
    case (addr[3:2])
      A_CTRL:   dout = {28'd0, r_im, r_mode, r_en};
      A_PRESET: dout = r_preset;
      A_COUNT:  dout = r_count;
      default:  dout = 32'd0;
    endcase

    irq = r_irq_flag && r_im;
  end

  // A software CTRL write overrides the one-shot EN clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_mode <= 2'd0;
      r_im   <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en   <= din[0];
      r_mode <= din[2:1];
      r_im   <= din[3];
    end else if (w_clr_en) begin
      r_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_preset <= 32'd0;
    else if (w_wr_preset) r_preset <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_count <= 32'd0;
    else if (w_load) r_count <= r_preset;
    else if (w_dec)  r_count <= r_count - 32'd1;
  end

  // Setting on zero detect beats any clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_irq_flag <= 1'b0;
    else if (w_set_flag)
      r_irq_flag <= 1'b1;
    else if (w_wr_ctrl || w_wr_preset || w_reload_clr)
      r_irq_flag <= 1'b0;
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: one-shot, auto-reload, masking, disable,
// boundary presets and same-edge collisions, with hand-computed expectations.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F10;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_total = 0;
  int n_pass  = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    addr = BASE + off;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    addr = BASE + off;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  logic [31:0] ar_count [1:6] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = BASE;
    din   = 32'd0;
    tick(2);

    // Reset state
    rd("rst_ctrl", 32'h0, 32'd0);
    rd("rst_preset", 32'h4, 32'd0);
    rd("rst_count", 32'h8, 32'd0);
    chk_irq("rst_irq", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick(5);
    rd("idle_ctrl", 32'h0, 32'd0);
    rd("idle_count", 32'h8, 32'd0);
    chk_irq("idle_irq", 1'b0);

    // One-shot, PRESET=5
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    tick(2);
    rd("os_count_e2", 32'h8, 32'd5);
    chk_irq("os_irq_e2", 1'b0);
    tick(5);
    rd("os_count_e7", 32'h8, 32'd0);
    chk_irq("os_irq_e7", 1'b0);
    tick(1);
    chk_irq("os_irq_e8", 1'b1);
    tick(1);
    rd("os_ctrl_e9", 32'h0, 32'h8);
    chk_irq("os_irq_hold", 1'b1);
    wr(32'h0, 32'h8);
    chk_irq("os_irq_clear", 1'b0);

    // Auto-reload, PRESET=3: pulses 6 cycles apart
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    tick(6);
    chk_irq("ar_irq_e6", 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk_irq($sformatf("ar_irq_e%0d", 6 + i), (i == 6));
      rd($sformatf("ar_count_e%0d", 6 + i), 32'h8, ar_count[i]);
    end

    // PRESET write mid-run: current run unchanged, next reload uses it
    tick(2);
    rd("pw_count_e14", 32'h8, 32'd3);
    wr(32'h4, 32'd1);
    rd("pw_count_e15", 32'h8, 32'd2);
    tick(2);
    rd("pw_count_e17", 32'h8, 32'd0);
    tick(1);
    chk_irq("pw_irq_e18", 1'b1);
    tick(2);
    rd("pw_reload_e20", 32'h8, 32'd1);
    wr(32'h0, 32'h0);
    tick(2);
    chk_irq("pw_stop_irq", 1'b0);

    // Masked one-shot: irq never asserts, EN clears after expiry
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk_irq($sformatf("mask_irq_e%0d", i), 1'b0);
    end
    rd("mask_ctrl", 32'h0, 32'h0);
    wr(32'h0, 32'h8);
    chk_irq("mask_flag_cleared", 1'b0);

    // Disable mid-count: COUNT freezes
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    tick(4);
    rd("dis_count_e4", 32'h8, 32'd8);
    wr(32'h0, 32'h0);
    rd("dis_count_e5", 32'h8, 32'd7);
    tick(1);
    rd("dis_count_e6", 32'h8, 32'd7);
    tick(3);
    rd("dis_count_e9", 32'h8, 32'd7);

    // Zero preset: irq_flag 3 edges after the CTRL write
    wr(32'h4, 32'd0);
    wr(32'h0, 32'h9);
    tick(2);
    rd("zero_count_e2", 32'h8, 32'd0);
    chk_irq("zero_irq_e2", 1'b0);
    tick(1);
    chk_irq("zero_irq_e3", 1'b1);
    tick(1);
    rd("zero_ctrl_e4", 32'h0, 32'h8);

    // Set beats clear on the zero-detect edge; CTRL write wins on the INT edge
    wr(32'h0, 32'h8);
    chk_irq("col_flag_clear", 1'b0);
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    tick(4);
    rd("col_count_e4", 32'h8, 32'd0);
    wr(32'h4, 32'd2);
    chk_irq("col_set_wins", 1'b1);
    wr(32'h0, 32'h3);
    rd("col_ctrl_wins", 32'h0, 32'h3);
    chk_irq("col_irq_masked", 1'b0);
    tick(2);
    rd("col_restart_e8", 32'h8, 32'd2);

    // Max preset, read-only COUNT, unused offset, no restart on EN rewrite
    wr(32'h0, 32'h0);
    tick(1);
    wr(32'h4, 32'hFFFF_FFFF);
    rd("max_preset", 32'h4, 32'hFFFF_FFFF);
    wr(32'h0, 32'h1);
    tick(2);
    rd("max_count_e2", 32'h8, 32'hFFFF_FFFF);
    tick(1);
    rd("max_count_e3", 32'h8, 32'hFFFF_FFFE);
    wr(32'h8, 32'h0000_1234);
    rd("ro_count", 32'h8, 32'hFFFF_FFFD);
    rd("off_c_read", 32'hC, 32'd0);
    wr(32'h0, 32'h9);
    rd("norestart_count", 32'h8, 32'hFFFF_FFFC);
    rd("norestart_ctrl", 32'h0, 32'h9);

    // Asynchronous reset mid-count
    #2;
    reset = 1'b0;
    rd("arst_ctrl", 32'h0, 32'd0);
    rd("arst_preset", 32'h4, 32'd0);
    rd("arst_count", 32'h8, 32'd0);
    chk_irq("arst_irq", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped timer/counter peripheral. It is the responder on the bridge's timer window: the bridge decodes a timer address range and drives this block's write enable. A CPU store programs the control and preset registers, and the block reads back over the bridge's data path. The block down-counts from the preset value and raises an interrupt request toward the CPU's exception logic. The design instantiates two copies, at 0x7F00 and 0x7F10.

## Interface
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-low reset
- `addr`  input  32  full byte address; only `addr[3:2]` is decoded (0 CTRL, 1 PRESET, 2 COUNT, 3 unused)
- `we`  input  1  word write enable, from the bridge's per-timer write enable (asserted only for full-word stores)
- `din`  input  32  write data
- `dout`  output  32  combinational read of the register selected by `addr[3:2]`
- `irq`  output  1  interrupt request, equal to `irq_flag & CTRL.IM`

## Operation
- **CTRL register (offset 0x0)**
  - bit0 EN: counter enable
  - bits2:1 MODE: 0 = one-shot, 1 = auto-reload; 2 and 3 behave as 0
  - bit3 IM: interrupt mask, 1 = irq enabled
  - bits31:4 are not stored and read as 0.
- **PRESET register (0x4):** 32-bit, read/write.
- **COUNT register (0x8):** 32-bit, read-only; writes are ignored.
- **Offset 0xC:** reads 0; writes are ignored.
- **Writes:** a write to CTRL or PRESET also clears `irq_flag` on the same edge.
- **FSM states:** IDLE, LOAD, CNT, INT.
  - IDLE: stays in IDLE while EN=0. If EN=1 at the edge, go to LOAD.
  - LOAD: COUNT <= PRESET, then go to CNT.
  - CNT, evaluated in priority order:
    - EN=0: go to IDLE; COUNT holds.
    - COUNT != 0: COUNT <= COUNT-1.
    - COUNT == 0: set `irq_flag`, go to INT.
  - INT, MODE 0: clear EN, go to IDLE. `irq_flag` stays set until software writes CTRL or PRESET.
  - INT, MODE 1: go to LOAD and clear `irq_flag`, giving a one-cycle pulse. Counting repeats indefinitely.
- **Arithmetic:** COUNT is 32-bit unsigned. A decrement never occurs at 0, so COUNT never wraps.
- **Simultaneous events:**
  - A software CTRL write on the same edge as INT clearing EN: the software value wins.
  - A PRESET write during CNT does not disturb COUNT. It takes effect at the next LOAD.
  - A CTRL write with EN=1 while in CNT does not restart the count.
  - A write that clears `irq_flag` on the same edge the CNT→INT transition sets it: the set wins.
- **Zero preset:** PRESET=0 gives LOAD → CNT (COUNT=0) → INT, i.e. `irq_flag` sets 2 edges after LOAD.

## Timing
- **Reset values:** CTRL=0, PRESET=0, COUNT=0, state IDLE, `irq_flag`=0, `irq`=0. `dout` is therefore 0 for every address.
- **Asynchronous reset:** asserting `reset` mid-count forces all of the above immediately, independent of `clk`.
- **Register writes:** visible on `dout` in the cycle after the write edge.
- **Start latency:** CTRL write with EN=1 at edge E0.
  - E1: IDLE → LOAD
  - E2: COUNT=P, state CNT
  - E2+P: COUNT reaches 0
  - E3+P: `irq_flag` set; `irq` high from then on if IM=1
- **Auto-reload period:** P+3 cycles per interrupt (INT → LOAD → CNT → P decrements → zero detect).
- **Output paths:** `irq` and `dout` are combinational from registered state. There are no bus wait states; every access completes in one cycle.

## Test plan
- **Reset:** hold `reset`=0, drive `addr`=0x0, 0x4, 0x8 → `dout`=0 and `irq`=0. Release, idle 5 cycles → values unchanged.
- **One-shot:**
  - Stimulus: write PRESET=5, then CTRL=0x9 (EN, MODE 0, IM) at edge E0.
  - Required response: COUNT reads 5 after E2 and 0 after E7; `irq` rises after E8; CTRL reads 0x8.
  - Then write CTRL=0x8 → `irq` falls the next cycle.
- **Auto-reload:** PRESET=3, CTRL=0xB → `irq` one-cycle pulses exactly 6 cycles apart, with COUNT sequence 3,2,1,0 repeating. `irq_flag` never stays set.
- **Mask and disable:**
  - CTRL=0x1 (IM=0), PRESET=2 → `irq` never asserts, CTRL EN clears after expiry.
  - Writing CTRL=0x0 mid-count → state IDLE next edge, COUNT frozen at its current value.
- **Boundaries:**
  - PRESET=0 with EN=1 → `irq_flag` 3 edges after the CTRL write.
  - PRESET=0xFFFFFFFF → first decrement gives 0xFFFFFFFE.
  - Write COUNT=0x1234 → COUNT unchanged.
  - Offset 0xC reads 0.
- **Collisions:**
  - PRESET write during CNT → current run unaffected, next reload uses the new value.
  - CTRL write of 0x3 on the INT edge in MODE 0 → CTRL reads 0x3, not EN-cleared.
  - Assert `reset` mid-count → all outputs 0 immediately.
